// File: rtl/ife_pkg.sv
// Shared definitions for the image-filter engine pass sequencer:
// filter modes, image geometry and sequencer state encoding.
package ife_pkg;

    localparam int unsigned IMG_W = 128;
    localparam int unsigned NPIX  = IMG_W * IMG_W;

    typedef enum logic [1:0] {
        SEL_MEAN3 = 2'd0,
        SEL_MEAN5 = 2'd1,
        SEL_MAX3  = 2'd2,
        SEL_THR   = 2'd3
    } sel_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/ife_wdog.sv
// Progress watchdog: loads on clear, counts down while enabled,
// flags expiry once the count is exhausted.
module ife_wdog #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] LOAD  = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/ife_pass_sequencer.sv
// Runs a programmed chain of filter passes on the engine, ping-ponging
// the source/destination image banks and watching for stalls.
module ife_pass_sequencer #(
    parameter int unsigned NPIX     = ife_pkg::NPIX,
    parameter int unsigned MAX_PASS = 4,
    parameter int unsigned RST_CYC  = 2,
    parameter int unsigned WDOG     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_idx,
    input  logic [1:0] cfg_sel,
    input  logic [2:0] cfg_len,
    input  logic       start,
    output logic       running,
    output logic       done,
    output logic       err_timeout,
    output logic       err_cfg,
    output logic [1:0] pass_idx,
    output logic       final_bank,
    output logic       eng_rst,
    output logic [1:0] eng_sel,
    input  logic       eng_busy,
    input  logic       eng_wen,
    output logic       src_bank,
    output logic       dst_bank
);

    import ife_pkg::*;

    localparam int unsigned WD_W = $clog2(WDOG + 1);

    seq_state_t  state, state_next;
    sel_t        tbl [MAX_PASS];
    logic [2:0]  len;
    logic [14:0] wcnt;
    logic [3:0]  rcnt;
    logic        idle_like, len_ok, last_pix, more_pass;
    logic        wd_clr, wd_en, wd_expire, timeout;

    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        len_ok    = (cfg_len != 3'd0) && (cfg_len <= 3'(MAX_PASS));
        last_pix  = eng_wen && (wcnt == 15'(NPIX - 1));
        more_pass = ({1'b0, pass_idx} + 3'd1) < len;
        wd_en     = (state == LAUNCH) || (state == RUN);
        // a write strobe in the expiring cycle still counts as progress
        timeout   = wd_expire && !eng_wen;

        state_next = state;
        case (state)
            IDLE, DONE: if (start && len_ok) state_next = RST;
            RST:        if (rcnt == 4'(RST_CYC - 1)) state_next = LAUNCH;
            LAUNCH: begin
                if (timeout)       state_next = IDLE;
                else if (eng_busy) state_next = RUN;
            end
            RUN: begin
                if (last_pix)     state_next = DRAIN;
                else if (timeout) state_next = IDLE;
            end
            DRAIN:   state_next = more_pass ? RST : DONE;
            default: state_next = IDLE;
        endcase

        wd_clr  = (state_next != state) || eng_wen;
        eng_rst = !wd_en;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MAX_PASS; i++) tbl[i] <= SEL_MEAN3;
            len         <= '0;
            wcnt        <= '0;
            rcnt        <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_cfg     <= 1'b0;
            pass_idx    <= '0;
            src_bank    <= 1'b0;
            final_bank  <= 1'b0;
            eng_sel     <= SEL_MEAN3;
        end else begin
            done <= 1'b0;
            rcnt <= (state == RST) ? rcnt + 4'd1 : '0;

            if (cfg_wr && idle_like) tbl[cfg_idx] <= sel_t'(cfg_sel);
            if (state == RST) eng_sel <= tbl[pass_idx];

            if (state != RUN)  wcnt <= '0;
            else if (eng_wen)  wcnt <= wcnt + 15'd1;

            if (timeout) begin
                err_timeout <= 1'b1;
                running     <= 1'b0;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len         <= cfg_len;
                        err_timeout <= 1'b0;
                        err_cfg     <= !len_ok;
                        if (len_ok) begin
                            pass_idx <= '0;
                            src_bank <= 1'b0;
                            running  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (more_pass) begin
                        pass_idx <= pass_idx + 2'd1;
                        src_bank <= ~src_bank;
                    end else begin
                        final_bank <= ~src_bank;
                        done       <= 1'b1;
                        running    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dst_bank = ~src_bank;

    ife_wdog #(
        .WIDTH (WD_W),
        .LOAD  (WD_W'(WDOG - 1))
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

endmodule

// File: tb/tb_ife_pass_sequencer.sv
// Self-checking bench for ife_pass_sequencer with a behavioural engine model
// and a table/bank reference derived from the pass-chain rules.
module tb_ife_pass_sequencer;

    import ife_pkg::*;

    localparam int unsigned RST_CYC = 2;
    localparam int unsigned WDOG    = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [1:0] cfg_sel = '0;
    logic [2:0] cfg_len = '0;
    logic       start = 1'b0;
    logic       eng_busy = 1'b0;
    logic       eng_wen = 1'b0;
    logic       running, done, err_timeout, err_cfg, final_bank;
    logic       eng_rst, src_bank, dst_bank;
    logic [1:0] pass_idx, eng_sel;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned done_cnt = 0;
    logic [1:0]  tbl_m [4];

    ife_pass_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_idx     (cfg_idx),
        .cfg_sel     (cfg_sel),
        .cfg_len     (cfg_len),
        .start       (start),
        .running     (running),
        .done        (done),
        .err_timeout (err_timeout),
        .err_cfg     (err_cfg),
        .pass_idx    (pass_idx),
        .final_bank  (final_bank),
        .eng_rst     (eng_rst),
        .eng_sel     (eng_sel),
        .eng_busy    (eng_busy),
        .eng_wen     (eng_wen),
        .src_bank    (src_bank),
        .dst_bank    (dst_bank)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_200_000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; cfg_wr = 1'b0; eng_busy = 1'b0; eng_wen = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tbl_m[i] = 2'd0;
        tick();
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [1:0] sel);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_sel = sel;
        tick();
        cfg_wr = 1'b0;
        tbl_m[idx] = sel;
    endtask

    task automatic start_chain(input logic [2:0] l, input bit wr, input logic [1:0] idx,
                               input logic [1:0] sel);
        start = 1'b1; cfg_len = l;
        if (wr) begin cfg_wr = 1'b1; cfg_idx = idx; cfg_sel = sel; end
        tick();
        start = 1'b0; cfg_wr = 1'b0;
        if (wr) tbl_m[idx] = sel;
    endtask

    // Waits for the engine release, checks the pass setup, then plays nwen writes.
    task automatic engine_pass(input logic [1:0] exp_sel, input logic exp_src,
                               input logic [1:0] exp_idx, input int unsigned nwen,
                               output int unsigned rst_hi);
        int unsigned bad;
        rst_hi = 0;
        while (eng_rst === 1'b1 && rst_hi < 64) begin tick(); rst_hi++; end
        n_cmp++;
        if (eng_rst !== 1'b0) begin
            $display("FAIL launch eng_rst=%b required 0", eng_rst); n_fail++;
        end
        n_cmp++;
        if (eng_sel !== exp_sel || src_bank !== exp_src || dst_bank !== ~exp_src ||
            pass_idx !== exp_idx || running !== 1'b1) begin
            $display("FAIL pass_setup sel=%0d src=%b dst=%b idx=%0d run=%b required sel=%0d src=%b dst=%b idx=%0d run=1",
                     eng_sel, src_bank, dst_bank, pass_idx, running, exp_sel, exp_src, ~exp_src, exp_idx);
            n_fail++;
        end
        repeat ($urandom_range(0, 3)) tick();
        eng_busy = 1'b1;
        tick();
        bad = 0;
        for (int unsigned i = 0; i < nwen; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                eng_wen = 1'b0;
                repeat ($urandom_range(1, 2)) begin
                    tick();
                    if (eng_rst !== 1'b0 || eng_sel !== exp_sel) bad++;
                end
            end
            eng_wen = 1'b1;
            tick();
            if (i != nwen - 1 && (eng_rst !== 1'b0 || eng_sel !== exp_sel)) bad++;
        end
        eng_wen = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL pass_stable %0d cycles with eng_rst/eng_sel wrong, required 0 (sel=%0d)", bad, exp_sel);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        int unsigned hi, bad, d0;
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (running !== 0 || done !== 0 || err_timeout !== 0 || err_cfg !== 0 || pass_idx !== 0) begin
            $display("FAIL reset_status run=%b done=%b et=%b ec=%b idx=%0d required all 0",
                     running, done, err_timeout, err_cfg, pass_idx);
            n_fail++;
        end
        n_cmp++;
        if (eng_rst !== 1 || eng_sel !== 0 || src_bank !== 0 || dst_bank !== 1 || final_bank !== 0) begin
            $display("FAIL reset_engine rst=%b sel=%0d src=%b dst=%b fin=%b required 1 0 0 1 0",
                     eng_rst, eng_sel, src_bank, dst_bank, final_bank);
            n_fail++;
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tbl_m[i] = 2'd0;
        tick();
        cfg_write(2'd0, SEL_THR);
        start_chain(3'd1, 0, 2'd0, 2'd0);
        engine_pass(tbl_m[0], 1'b0, 2'd0, $urandom_range(20, 200), hi);
        d0 = done_cnt;
        reset = 1'b0;
        bad = 0;
        repeat (3) begin
            tick();
            if (eng_rst !== 1 || running !== 0 || src_bank !== 0 || pass_idx !== 0) bad++;
        end
        reset = 1'b1;
        eng_busy = 1'b0;
        for (int i = 0; i < 4; i++) tbl_m[i] = 2'd0;
        n_cmp++;
        if (bad != 0) begin
            $display("FAIL reset_midrun %0d bad cycles required 0", bad); n_fail++;
        end
        repeat (10) tick();
        n_cmp++;
        if (running !== 0 || eng_rst !== 1 || done_cnt != d0) begin
            $display("FAIL reset_after run=%b rst=%b dones=%0d required 0 1 %0d", running, eng_rst, done_cnt, d0);
            n_fail++;
        end
        // table entries must have returned to mode 0
        start_chain(3'd1, 0, 2'd0, 2'd0);
        engine_pass(tbl_m[0], 1'b0, 2'd0, 10, hi);
        do_reset();
    endtask

    task automatic test_cfg_err();
        logic [2:0] bad_len [3];
        bad_len[0] = 3'd0;
        bad_len[1] = 3'd5;
        bad_len[2] = 3'($urandom_range(5, 7));
        for (int k = 0; k < 3; k++) begin
            start_chain(bad_len[k], 0, 2'd0, 2'd0);
            repeat ($urandom_range(0, 4)) tick();
            n_cmp++;
            if (err_cfg !== 1 || running !== 0 || eng_rst !== 1) begin
                $display("FAIL cfg_err len=%0d ec=%b run=%b rst=%b required 1 0 1",
                         bad_len[k], err_cfg, running, eng_rst);
                n_fail++;
            end
        end
        start_chain(3'd2, 0, 2'd0, 2'd0);
        n_cmp++;
        if (err_cfg !== 0 || running !== 1) begin
            $display("FAIL cfg_err_clear ec=%b run=%b required 0 1", err_cfg, running); n_fail++;
        end
        do_reset();
    endtask

    task automatic test_same_cycle();
        int unsigned hi;
        cfg_write(2'd0, SEL_MEAN5);
        start_chain(3'd1, 1, 2'd0, SEL_MAX3);
        engine_pass(tbl_m[0], 1'b0, 2'd0, $urandom_range(50, 300), hi);
        n_cmp++;
        if (tbl_m[0] !== 2'd2) begin
            $display("FAIL same_cycle_model entry=%0d required 2", tbl_m[0]); n_fail++;
        end
        start = 1'b1; cfg_len = 3'd2;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (running !== 1 || eng_rst !== 0 || err_cfg !== 0 || eng_sel !== 2'd2 || pass_idx !== 0) begin
            $display("FAIL start_while_running run=%b rst=%b ec=%b sel=%0d idx=%0d required 1 0 0 2 0",
                     running, eng_rst, err_cfg, eng_sel, pass_idx);
            n_fail++;
        end
        do_reset();
    endtask

    task automatic test_single_pass();
        int unsigned hi, d0;
        cfg_write(2'd0, SEL_MEAN5);
        d0 = done_cnt;
        start_chain(3'd1, 0, 2'd0, 2'd0);
        engine_pass(tbl_m[0], 1'b0, 2'd0, NPIX, hi);
        n_cmp++;
        if (hi + 1 != RST_CYC + 1) begin
            $display("FAIL start_latency %0d cycles required %0d", hi + 1, RST_CYC + 1); n_fail++;
        end
        eng_busy = 1'b0;
        n_cmp++;
        if (done !== 0 || eng_rst !== 1) begin
            $display("FAIL drain_cycle done=%b rst=%b required 0 1", done, eng_rst); n_fail++;
        end
        tick();
        n_cmp++;
        if (done !== 1 || final_bank !== 1 || running !== 0) begin
            $display("FAIL single_done done=%b fin=%b run=%b required 1 1 0", done, final_bank, running); n_fail++;
        end
        tick();
        n_cmp++;
        if (done !== 0 || done_cnt != d0 + 1) begin
            $display("FAIL single_pulse done=%b pulses=%0d required 0 %0d", done, done_cnt - d0, 1); n_fail++;
        end
    endtask

    task automatic test_chain();
        int unsigned hi, d0;
        logic [2:0] l;
        l = 3'd3;
        cfg_write(2'd0, SEL_MEAN3);
        cfg_write(2'd1, SEL_MAX3);
        cfg_write(2'd2, SEL_THR);
        cfg_write(2'd3, 2'($urandom_range(0, 3)));
        d0 = done_cnt;
        start_chain(l, 0, 2'd0, 2'd0);
        for (int p = 0; p < int'(l); p++) begin
            engine_pass(tbl_m[p], 1'(p % 2), 2'(p), NPIX, hi);
            if (p > 0) begin
                n_cmp++;
                if (hi != RST_CYC + 1) begin
                    $display("FAIL interpass_rst pass=%0d eng_rst high %0d cycles required %0d", p, hi, RST_CYC + 1);
                    n_fail++;
                end
            end
            eng_busy = 1'b0;
            n_cmp++;
            if (done !== 0 || eng_rst !== 1) begin
                $display("FAIL chain_drain pass=%0d done=%b rst=%b required 0 1", p, done, eng_rst); n_fail++;
            end
        end
        tick();
        n_cmp++;
        if (done !== 1 || final_bank !== l[0] || running !== 0 || pass_idx !== 2'(l - 1)) begin
            $display("FAIL chain_done done=%b fin=%b run=%b idx=%0d required 1 %b 0 %0d",
                     done, final_bank, running, pass_idx, l[0], l - 1);
            n_fail++;
        end
        repeat (3) tick();
        n_cmp++;
        if (done_cnt != d0 + 1 || err_timeout !== 0 || err_cfg !== 0) begin
            $display("FAIL chain_single_done pulses=%0d et=%b ec=%b required 1 0 0",
                     done_cnt - d0, err_timeout, err_cfg);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        int unsigned hi, t, d0;
        cfg_write(2'd0, 2'($urandom_range(0, 3)));
        d0 = done_cnt;
        start_chain(3'd1, 0, 2'd0, 2'd0);
        engine_pass(tbl_m[0], 1'b0, 2'd0, 100, hi);
        t = 0;
        while (err_timeout !== 1'b1 && t < 400) begin tick(); t++; end
        n_cmp++;
        if (t != WDOG) begin
            $display("FAIL timeout_delay %0d idle cycles required %0d", t, WDOG); n_fail++;
        end
        n_cmp++;
        if (eng_rst !== 1 || running !== 0) begin
            $display("FAIL timeout_state rst=%b run=%b required 1 0", eng_rst, running); n_fail++;
        end
        repeat (40) tick();
        eng_busy = 1'b0;
        n_cmp++;
        if (err_timeout !== 1 || done_cnt != d0) begin
            $display("FAIL timeout_sticky et=%b pulses=%0d required 1 0", err_timeout, done_cnt - d0); n_fail++;
        end
        start_chain(3'd1, 0, 2'd0, 2'd0);
        n_cmp++;
        if (err_timeout !== 0 || running !== 1) begin
            $display("FAIL timeout_clear et=%b run=%b required 0 1", err_timeout, running); n_fail++;
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_cfg_err();
        test_same_cycle();
        test_single_pass();
        test_chain();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
